nand_op_sequencer: RTL and testbench
====================================

Name: nand_op_sequencer

Overview:
- Multi-cycle logic unit. Every result is computed from one shared W-bit 2-input NAND stage, reused once per clock cycle.
- A small state machine sequences the NAND stage through the standard gate-conversion networks: NOT, AND, OR, NOR, XOR, XNOR and BUF, each built from NAND.
- Sits beside the gate-conversion library as the sequential, resource-shared counterpart of the one-gate-per-function combinational conversions.

Parameters:
- W, 4, operand/result width in bits (bitwise ops).
- CNT_W, 16, width of the NAND-evaluation counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while idle (busy=0).
- op  input  3  operation select; latched with start.
- a  input  W  operand A; latched with start.
- b  input  W  operand B; latched with start.
- busy  output  1  high while a sequence is executing.
- done  output  1  one-cycle pulse when y is updated.
- y  output  W  registered result; holds the last completed value.
- nand_count  output  CNT_W  total NAND-stage evaluations since reset.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, y=0, nand_count=0; internal latches t1..t3, step, op, a, b cleared. Reset mid-sequence aborts it: no done pulse, y=0.
- The shared stage computes nand(x,z) = ~(x & z), bitwise over W bits. Exactly one evaluation per RUN cycle, none in IDLE.
- Op encoding, NAND steps N, and step sequence (t = internal temp registers, last step writes y):
- 000 NOT: N=1. y=nand(a,a).
- 001 AND: N=2. t1=nand(a,b); y=nand(t1,t1).
- 010 OR: N=3. t1=nand(a,a); t2=nand(b,b); y=nand(t1,t2).
- 011 NOR: N=4. OR steps into t3, then y=nand(t3,t3).
- 100 XOR: N=4. t1=nand(a,b); t2=nand(a,t1); t3=nand(b,t1); y=nand(t2,t3).
- 101 XNOR: N=5. XOR steps with the 4th result held in t1, then y=nand(t1,t1).
- 110 NAND: N=1. y=nand(a,b).
- 111 BUF: N=2. t1=nand(a,a); y=nand(t1,t1).
- FSM has two states, IDLE and RUN.
- IDLE: on an edge with start=1, latch op/a/b, set step=0, go to RUN, and set busy=1 at that edge.
- RUN: each edge executes step `step`, increments step and nand_count (nand_count wraps modulo 2^CNT_W).
- RUN, final step (step==N-1): y registered with the result, done=1 for exactly that following cycle, busy=0, go to IDLE.
- Latency: start sampled at edge E0 -> done and new y visible after edge E0+N; busy high from E0 to E0+N.
- start while busy=1: ignored, no queuing.
- a/b/op changes while busy: no effect, since operands are latched.
- start=1 in the done cycle (busy=0): accepted. Back-to-back sequences are legal, with throughput of one op per N cycles.
- y changes only on a final step or reset. done never asserts without a y update.
- Intermediate values are never visible on y.

Test Plan:
- Reset/idle: rst=1 pulsed asynchronously mid-cycle -> busy=0, done=0, y=0000, nand_count=0 immediately; with start=0 no change for 10 cycles.
- XOR, W=4: a=1100, b=1010, op=100, start 1 cycle -> busy high 4 cycles, then done pulse, y=0110, nand_count=4.
- Full op sweep: a=1100, b=1010, ops 000..111 run back-to-back (start held in each done cycle).
  - Expected y: 0011, 1000, 1110, 0001, 0110, 1001, 0111, 1100.
  - Latencies: 1, 2, 3, 4, 4, 5, 1, 2.
  - Final nand_count=22.
- Busy immunity: start XNOR (a=1111, b=0101), then change a/b/op and pulse start during busy -> single done after 5 cycles, y=0101, nand_count +5 only.
- Reset mid-op: start NOR (a=0000, b=0000), assert rst after 2 RUN cycles -> no done pulse, y=0000, nand_count=0. A new NOT start with a=0101 then gives y=1010 after 1 cycle.
- Counter wrap with CNT_W=3: run three NOR ops (12 evaluations) -> nand_count=100 (12 mod 8 = 4).

Source files
------------

// File: rtl/nand_op_sequencer.sv
// Multi-cycle bitwise logic unit: one shared W-bit NAND stage is stepped through
// the NAND-only conversion network of the selected operation, one evaluation per cycle.
module nand_op_sequencer #(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     y,
  output logic [CNT_W-1:0] nand_count
);

  // Handshake: start is a request accepted on any rising edge where busy=0;
  // done pulses for one cycle alongside the y update and never otherwise.
  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_nxt;
  logic [2:0]   step, op_r, n_steps;
  logic [W-1:0] a_r, b_r, t1, t2, t3;
  logic [W-1:0] nx, nz, nres;
  logic [1:0]   dst;
  logic         last;

  always_comb begin
    case (op_r)
      3'b000:  n_steps = 3'd1;
      3'b001:  n_steps = 3'd2;
      3'b010:  n_steps = 3'd3;
      3'b011:  n_steps = 3'd4;
      3'b100:  n_steps = 3'd4;
      3'b101:  n_steps = 3'd5;
      3'b110:  n_steps = 3'd1;
      default: n_steps = 3'd2;
    endcase
  end

  assign last = (step == n_steps - 3'd1);

  // Operand routing into the shared stage; dst names the temp written on non-final steps.
  always_comb begin
    nx  = a_r;
    nz  = a_r;
    dst = 2'd1;
    case (op_r)
      3'b000: ;
      3'b001: begin
        if (step == 3'd0) nz = b_r;
        else begin nx = t1; nz = t1; end
      end
      3'b010, 3'b011: begin
        case (step)
          3'd0:    dst = 2'd1;
          3'd1:    begin nx = b_r; nz = b_r; dst = 2'd2; end
          3'd2:    begin nx = t1;  nz = t2;  dst = 2'd3; end
          default: begin nx = t3;  nz = t3; end
        endcase
      end
      3'b100, 3'b101: begin
        case (step)
          3'd0:    begin nz = b_r; dst = 2'd1; end
          3'd1:    begin nz = t1;  dst = 2'd2; end
          3'd2:    begin nx = b_r; nz = t1; dst = 2'd3; end
          3'd3:    begin nx = t2;  nz = t3; dst = 2'd1; end
          default: begin nx = t1;  nz = t1; end
        endcase
      end
      3'b110: nz = b_r;
      default: begin
        if (step != 3'd0) begin nx = t1; nz = t1; end
      end
    endcase
  end

  assign nres = ~(nx & nz);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      default: if (last)  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step       <= '0;
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      t1         <= '0;
      t2         <= '0;
      t3         <= '0;
      y          <= '0;
      done       <= 1'b0;
      nand_count <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          op_r <= op;
          a_r  <= a;
          b_r  <= b;
          step <= '0;
        end
      end else begin
        step       <= step + 3'd1;
        nand_count <= nand_count + CNT_W'(1);
        if (last) begin
          y    <= nres;
          done <= 1'b1;
        end else begin
          case (dst)
            2'd1:    t1 <= nres;
            2'd2:    t2 <= nres;
            default: t3 <= nres;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Bench for nand_op_sequencer: randomized ops against a boolean reference model,
// with expected results queued at issue time and checked by a done-driven monitor.
module tb_nand_op_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, busy3, done3;
  logic [W-1:0] y, y3;
  logic [15:0]  nand_count;
  logic [2:0]   nand_count3;

  int errors = 0, checks = 0, cyc = 0;
  logic [W-1:0] exp_q[$];
  int exp_cyc_q[$], exp_cnt_q[$];
  int cnt_model = 0, run_s = 0, run_e = 0;
  logic [W-1:0] last_y = '0;
  logic [W-1:0] ey;
  int ec, en;

  nand_op_sequencer #(.W(W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .y(y), .nand_count(nand_count));

  nand_op_sequencer #(.W(W), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy3), .done(done3), .y(y3), .nand_count(nand_count3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] ref_y(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    case (o)
      3'd0:    return ~x;
      3'd1:    return x & z;
      3'd2:    return x | z;
      3'd3:    return ~(x | z);
      3'd4:    return x ^ z;
      3'd5:    return ~(x ^ z);
      3'd6:    return ~(x & z);
      default: return x;
    endcase
  endfunction

  function automatic int ref_n(input logic [2:0] o);
    int n_tab[8] = '{1, 2, 3, 4, 4, 5, 1, 2};
    return n_tab[o];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: busy window from the model, and a queue pop on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", {31'd0, busy}, {31'd0, (cyc >= run_s && cyc < run_e)});
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          ey = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          en = exp_cnt_q.pop_front();
          check("y", 32'(y), 32'(ey));
          check("y_cnt3", 32'(y3), 32'(ey));
          check("done_cycle", cyc, ec);
          check("nand_count", 32'(nand_count), en % 65536);
          check("nand_count_w3", 32'(nand_count3), en % 8);
          last_y = ey;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete(); exp_cyc_q.delete(); exp_cnt_q.delete();
    cnt_model = 0; run_s = 0; run_e = 0; last_y = '0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_y", 32'(y), 0);
    check("rst_count", 32'(nand_count), 0);
    check("rst_count3", 32'(nand_count3), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
  endtask

  task automatic launch(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    int n;
    n = ref_n(o);
    cnt_model += n;
    exp_q.push_back(ref_y(o, x, z));
    exp_cyc_q.push_back(cyc + 1 + n);
    exp_cnt_q.push_back(cnt_model);
    run_s = cyc + 1;
    run_e = cyc + 1 + n;
    start = 1'b1; op = o; a = x; b = z;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Ends on the done cycle so a following issue lands back-to-back.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z, input bit noisy);
    int n;
    n = ref_n(o);
    launch(o, x, z);
    for (int i = 0; i < n; i++) begin
      if (noisy && i < n - 1) begin
        start = 1'($urandom_range(0, 1));
        op = 3'($urandom_range(0, 7));
        a = W'($urandom_range(0, 15));
        b = W'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_y", 32'(y), 32'(last_y));
      check("idle_done", 32'(done), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    do_reset();
    idle(10);

    issue(3'b100, 4'b1100, 4'b1010, 1'b0);
    check("xor_y", 32'(y), 32'(4'b0110));
    check("xor_count", 32'(nand_count), 4);

    do_reset();
    for (int o = 0; o < 8; o++) issue(3'(o), 4'b1100, 4'b1010, 1'b0);
    check("sweep_count", 32'(nand_count), 22);

    issue(3'b101, 4'b1111, 4'b0101, 1'b1);
    check("immune_y", 32'(y), 32'(4'b0101));
    check("immune_count", 32'(nand_count), 27);

    launch(3'b011, 4'b0000, 4'b0000);
    @(negedge clk);
    do_reset();
    idle(6);
    issue(3'b000, 4'b0101, 4'b0000, 1'b0);
    check("post_abort_y", 32'(y), 32'(4'b1010));
    check("post_abort_count", 32'(nand_count), 1);

    do_reset();
    for (int i = 0; i < 3; i++) issue(3'b011, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'b0);
    check("wrap_count3", 32'(nand_count3), 32'(3'b100));
    check("wrap_count", 32'(nand_count), 12);

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

    idle(8);
    check("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
